fpsqrt_multi_issue: RTL and testbench

FPSQRT_MULTI_ISSUE -- requirements
Module: fpsqrt_multi_issue

---
 rtl/fpsqrt_multi_issue.sv | 124 ++++++++++++
 tb/tb_fpsqrt_multi_issue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpsqrt_multi_issue.sv
// Round-robin issue/retire front end for NUM_UNITS iterative sqrt units.
// Requests and results pass through combinationally; results retire in issue order.
module fpsqrt_multi_issue #(
    parameter int unsigned NUM_UNITS   = 2,
    parameter int unsigned OP_W        = 64,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic                          start_valid_i,
    output logic                          start_ready_o,
    input  logic [1:0]                    fp_format_i,
    input  logic [2:0]                    rm_i,
    input  logic [OP_W-1:0]               op_i,
    output logic                          finish_valid_o,
    input  logic                          finish_ready_i,
    output logic [OP_W-1:0]               res_o,
    output logic [4:0]                    fflags_o,
    output logic [NUM_UNITS-1:0]          u_start_valid_o,
    input  logic [NUM_UNITS-1:0]          u_start_ready_i,
    output logic [1:0]                    u_fp_format_o,
    output logic [2:0]                    u_rm_o,
    output logic [OP_W-1:0]               u_op_o,
    output logic                          u_flush_o,
    input  logic [NUM_UNITS-1:0]          u_finish_valid_i,
    output logic [NUM_UNITS-1:0]          u_finish_ready_o,
    input  logic [NUM_UNITS*OP_W-1:0]     u_res_i,
    input  logic [NUM_UNITS*5-1:0]        u_fflags_i,
    output logic [$clog2(NUM_UNITS+1)-1:0] outstanding_o,
    output logic                          timeout_o
);

    localparam int unsigned CNT_W = $clog2(NUM_UNITS + 1);
    localparam int unsigned PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned WD_W  = 16;

    logic [PTR_W-1:0] iptr_q, iptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             timeout_q, timeout_d;
    logic             can_issue, can_retire, issue, retire;

    // Combinational request/result steering
    always_comb begin
        can_issue        = (cnt_q < CNT_W'(NUM_UNITS)) & ~flush_i;
        can_retire       = (cnt_q != '0) & ~flush_i;

        start_ready_o    = u_start_ready_i[iptr_q] & can_issue;
        u_start_valid_o  = '0;
        u_start_valid_o[iptr_q] = start_valid_i & can_issue;
        issue            = start_valid_i & start_ready_o;

        u_op_o           = op_i;
        u_rm_o           = rm_i;
        u_fp_format_o    = fp_format_i;
        u_flush_o        = flush_i;

        finish_valid_o   = u_finish_valid_i[rptr_q] & can_retire;
        res_o            = u_res_i[rptr_q*OP_W +: OP_W];
        fflags_o         = u_fflags_i[rptr_q*5 +: 5];
        u_finish_ready_o = '0;
        u_finish_ready_o[rptr_q] = finish_ready_i & can_retire;
        retire           = finish_valid_o & finish_ready_i;

        outstanding_o    = cnt_q;
        timeout_o        = timeout_q;
    end

    // Pointer, occupancy and watchdog next state
    always_comb begin
        iptr_d    = iptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;

        if (issue) begin
            iptr_d = (iptr_q == PTR_W'(NUM_UNITS - 1)) ? '0 : iptr_q + 1'b1;
        end
        if (retire) begin
            rptr_d = (rptr_q == PTR_W'(NUM_UNITS - 1)) ? '0 : rptr_q + 1'b1;
        end
        case ({issue, retire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // Watchdog only runs while the oldest op sits unretired
        if (flush_i || retire || (cnt_q == '0)) begin
            wd_d = '0;
        end else if (wd_q < WD_W'(TIMEOUT_CYC)) begin
            wd_d = wd_q + 1'b1;
        end
        timeout_d = timeout_q | (wd_d == WD_W'(TIMEOUT_CYC));

        if (flush_i) begin
            iptr_d    = '0;
            rptr_d    = '0;
            cnt_d     = '0;
            wd_d      = '0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            iptr_q    <= iptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_fpsqrt_multi_issue.sv
// Directed bench for fpsqrt_multi_issue: reset-state vector table plus
// hand-written issue/retire, ordering, full, watchdog, flush and reset sequences.
module tb_fpsqrt_multi_issue;

    localparam int unsigned N    = 2;
    localparam int unsigned OW   = 64;
    localparam int unsigned TOUT = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_i;
    logic          start_valid_i;
    logic          start_ready_o;
    logic [1:0]    fp_format_i;
    logic [2:0]    rm_i;
    logic [OW-1:0] op_i;
    logic          finish_valid_o;
    logic          finish_ready_i;
    logic [OW-1:0] res_o;
    logic [4:0]    fflags_o;
    logic [N-1:0]  u_start_valid_o;
    logic [N-1:0]  u_start_ready_i;
    logic [1:0]    u_fp_format_o;
    logic [2:0]    u_rm_o;
    logic [OW-1:0] u_op_o;
    logic          u_flush_o;
    logic [N-1:0]  u_finish_valid_i;
    logic [N-1:0]  u_finish_ready_o;
    logic [N*OW-1:0] u_res_i;
    logic [N*5-1:0]  u_fflags_i;
    logic [$clog2(N+1)-1:0] outstanding_o;
    logic          timeout_o;

    int checks = 0;
    int errors = 0;
    int peak   = 0;

    always #5 clk = ~clk;

    fpsqrt_multi_issue #(.NUM_UNITS(N), .OP_W(OW), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .start_valid_i(start_valid_i), .start_ready_o(start_ready_o),
        .fp_format_i(fp_format_i), .rm_i(rm_i), .op_i(op_i),
        .finish_valid_o(finish_valid_o), .finish_ready_i(finish_ready_i),
        .res_o(res_o), .fflags_o(fflags_o),
        .u_start_valid_o(u_start_valid_o), .u_start_ready_i(u_start_ready_i),
        .u_fp_format_o(u_fp_format_o), .u_rm_o(u_rm_o), .u_op_o(u_op_o),
        .u_flush_o(u_flush_o),
        .u_finish_valid_i(u_finish_valid_i), .u_finish_ready_o(u_finish_ready_o),
        .u_res_i(u_res_i), .u_fflags_i(u_fflags_i),
        .outstanding_o(outstanding_o), .timeout_o(timeout_o)
    );

    typedef struct {
        logic       sv;
        logic [1:0] usr;
        logic       fl;
        logic       fr;
        logic [1:0] ufv;
        logic       exp_sr;
        logic [1:0] exp_usv;
        logic       exp_fv;
        logic [1:0] exp_ufr;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance one cycle; inputs are changed and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (int'(outstanding_o) > peak) peak = int'(outstanding_o);
    endtask

    task automatic issue_two();
        start_valid_i = 1'b1;
        u_finish_valid_i = 2'b00;
        tick();
        tick();
        start_valid_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; start_valid_i = 1'b0;
        fp_format_i = 2'd1; rm_i = 3'd3; op_i = 64'h4010_0000_0000_0000;
        finish_ready_i = 1'b1; u_start_ready_i = 2'b11; u_finish_valid_i = 2'b00;
        u_res_i = '0; u_fflags_i = '0;

        //            sv    usr    fl    fr    ufv    sr    usv    fv    ufr
        vecs[0] = '{1'b1, 2'b01, 1'b0, 1'b1, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00};
        vecs[1] = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 1'b0, 2'b00};
        vecs[2] = '{1'b0, 2'b11, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};
        vecs[3] = '{1'b1, 2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
        vecs[4] = '{1'b1, 2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 2'b01, 1'b0, 2'b00};

        #2;
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
        chk("pass_op", u_op_o, 64'h4010_0000_0000_0000);
        chk("pass_rm", 64'(u_rm_o), 64'd3);
        chk("pass_fmt", 64'(u_fp_format_o), 64'd1);

        // Combinational behaviour in the reset state, held in reset so nothing moves
        for (int i = 0; i < 5; i++) begin
            start_valid_i    = vecs[i].sv;
            u_start_ready_i  = vecs[i].usr;
            flush_i          = vecs[i].fl;
            finish_ready_i   = vecs[i].fr;
            u_finish_valid_i = vecs[i].ufv;
            #1;
            chk($sformatf("vec%0d_start_ready", i), 64'(start_ready_o), 64'(vecs[i].exp_sr));
            chk($sformatf("vec%0d_u_start_valid", i), 64'(u_start_valid_o), 64'(vecs[i].exp_usv));
            chk($sformatf("vec%0d_finish_valid", i), 64'(finish_valid_o), 64'(vecs[i].exp_fv));
            chk($sformatf("vec%0d_u_finish_ready", i), 64'(u_finish_ready_o), 64'(vecs[i].exp_ufr));
            chk($sformatf("vec%0d_u_flush", i), 64'(u_flush_o), 64'(vecs[i].fl));
        end
        start_valid_i = 1'b0; flush_i = 1'b0; finish_ready_i = 1'b1;
        u_start_ready_i = 2'b11; u_finish_valid_i = 2'b00;

        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Four back-to-back requests, round-robin issue, in-order retire
        peak = 0;
        start_valid_i = 1'b1; op_i = 64'h4010_0000_0000_0000; #1;
        chk("b2b_a_usv", 64'(u_start_valid_o), 64'b01);
        chk("b2b_a_ready", 64'(start_ready_o), 64'd1);
        tick();
        op_i = 64'h4022_0000_0000_0000; #1;
        chk("b2b_b_usv", 64'(u_start_valid_o), 64'b10);
        tick();
        op_i = 64'h4030_0000_0000_0000;
        u_finish_valid_i = 2'b01; u_res_i = {64'hDEAD, 64'h4000_0000_0000_0000}; #1;
        chk("b2b_full_ready", 64'(start_ready_o), 64'd0);
        chk("b2b_ra_valid", 64'(finish_valid_o), 64'd1);
        chk("b2b_ra_res", res_o, 64'h4000_0000_0000_0000);
        chk("b2b_ra_ufr", 64'(u_finish_ready_o), 64'b01);
        tick();
        u_finish_valid_i = 2'b10; u_res_i = {64'h4008_0000_0000_0000, 64'hBEEF}; #1;
        chk("b2b_c_usv", 64'(u_start_valid_o), 64'b01);
        chk("b2b_rb_res", res_o, 64'h4008_0000_0000_0000);
        chk("b2b_rb_ufr", 64'(u_finish_ready_o), 64'b10);
        tick();
        op_i = 64'h4039_0000_0000_0000;
        u_finish_valid_i = 2'b01; u_res_i = {64'hBEEF, 64'h4010_0000_0000_0000}; #1;
        chk("b2b_d_usv", 64'(u_start_valid_o), 64'b10);
        chk("b2b_rc_res", res_o, 64'h4010_0000_0000_0000);
        tick();
        start_valid_i = 1'b0;
        u_finish_valid_i = 2'b10; u_res_i = {64'h4014_0000_0000_0000, 64'hDEAD}; #1;
        chk("b2b_rd_valid", 64'(finish_valid_o), 64'd1);
        chk("b2b_rd_res", res_o, 64'h4014_0000_0000_0000);
        tick();
        u_finish_valid_i = 2'b00;
        chk("b2b_empty", 64'(outstanding_o), 64'd0);
        chk("b2b_peak", 64'(peak), 64'd2);

        // Unit 1 finishes long before unit 0: held until unit 0 retires
        issue_two();
        u_res_i = {64'h1111, 64'h0000}; u_fflags_i = {5'h01, 5'h10};
        u_finish_valid_i = 2'b10;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("ooo_hold%0d", k), 64'(finish_valid_o), 64'd0);
            tick();
        end
        u_finish_valid_i = 2'b11; #1;
        chk("ooo_r0_valid", 64'(finish_valid_o), 64'd1);
        chk("ooo_r0_res", res_o, 64'h0000);
        chk("ooo_r0_flags", 64'(fflags_o), 64'h10);
        tick();
        u_finish_valid_i = 2'b10; #1;
        chk("ooo_r1_valid", 64'(finish_valid_o), 64'd1);
        chk("ooo_r1_res", res_o, 64'h1111);
        chk("ooo_r1_flags", 64'(fflags_o), 64'h01);
        tick();
        u_finish_valid_i = 2'b00;
        chk("ooo_empty", 64'(outstanding_o), 64'd0);

        // Full with simultaneous retire: issue deferred one cycle
        issue_two();
        start_valid_i = 1'b1; u_finish_valid_i = 2'b01; #1;
        chk("full_cnt", 64'(outstanding_o), 64'd2);
        chk("full_ready", 64'(start_ready_o), 64'd0);
        chk("full_retire", 64'(finish_valid_o), 64'd1);
        tick();
        u_finish_valid_i = 2'b00; #1;
        chk("full_cnt_dip", 64'(outstanding_o), 64'd1);
        chk("full_ready_next", 64'(start_ready_o), 64'd1);
        chk("full_usv_next", 64'(u_start_valid_o), 64'b01);
        tick();
        start_valid_i = 1'b0; #1;
        chk("full_cnt_back", 64'(outstanding_o), 64'd2);

        // Flush with two outstanding
        flush_i = 1'b1; start_valid_i = 1'b1; u_finish_valid_i = 2'b11; #1;
        chk("flush_u_flush", 64'(u_flush_o), 64'd1);
        chk("flush_ready", 64'(start_ready_o), 64'd0);
        chk("flush_usv", 64'(u_start_valid_o), 64'b00);
        chk("flush_fv", 64'(finish_valid_o), 64'd0);
        chk("flush_ufr", 64'(u_finish_ready_o), 64'b00);
        tick();
        flush_i = 1'b0; u_finish_valid_i = 2'b00; #1;
        chk("flush_cnt", 64'(outstanding_o), 64'd0);
        chk("flush_iptr0", 64'(u_start_valid_o), 64'b01);
        tick();
        start_valid_i = 1'b0;
        u_finish_valid_i = 2'b01; u_res_i = {64'hAAAA, 64'h5555}; #1;
        chk("flush_rptr0", 64'(finish_valid_o), 64'd1);
        chk("flush_rptr0_res", res_o, 64'h5555);
        tick();
        u_finish_valid_i = 2'b00;
        chk("flush_drain", 64'(outstanding_o), 64'd0);

        // Watchdog: one op that never finishes
        start_valid_i = 1'b1; tick(); start_valid_i = 1'b0;
        for (int k = 1; k < 16; k++) tick();
        chk("wd_before", 64'(timeout_o), 64'd0);
        tick();
        chk("wd_at16", 64'(timeout_o), 64'd1);
        repeat (5) tick();
        chk("wd_sticky", 64'(timeout_o), 64'd1);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        chk("wd_flush_clr", 64'(timeout_o), 64'd0);
        chk("wd_flush_cnt", 64'(outstanding_o), 64'd0);

        // Asynchronous reset with one op outstanding
        start_valid_i = 1'b1; tick(); start_valid_i = 1'b0;
        repeat (16) tick();
        finish_ready_i = 1'b0; u_finish_valid_i = 2'b01; #1;
        chk("ar_pre_timeout", 64'(timeout_o), 64'd1);
        chk("ar_pre_fv", 64'(finish_valid_o), 64'd1);
        rst_n = 1'b0; #1;
        chk("ar_cnt", 64'(outstanding_o), 64'd0);
        chk("ar_timeout", 64'(timeout_o), 64'd0);
        chk("ar_fv", 64'(finish_valid_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
